// File: rtl/prog_delay_line.sv
// Runtime-programmable delay line: circular buffer plus a fill counter that gates
// output validity, so the storage array itself never needs a reset.
module prog_delay_line #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_enable,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cfg_load,
  input  logic [AW:0]      delay_cfg,
  input  logic             flush,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic [AW:0]      cur_delay
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic [AW:0]      cur_delay_q, cur_delay_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;

  logic [AW:0]      cfg_clamped;
  logic [AW:0]      d_eff;
  logic             flush_any;
  logic [AW:0]      fill_base;
  logic [AW:0]      fill_inc;
  logic [AW-1:0]    rd_off;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_data;

  always_comb begin
    cfg_clamped = delay_cfg;
    if (delay_cfg == '0) begin
      cfg_clamped = (AW+1)'(1);
    end else if (delay_cfg > (AW+1)'(DEPTH)) begin
      cfg_clamped = (AW+1)'(DEPTH);
    end
  end

  // A load takes effect on the same edge, including for a shift in that cycle.
  assign d_eff     = cfg_load ? cfg_clamped : cur_delay_q;
  assign flush_any = cfg_load | flush;
  assign fill_base = flush_any ? '0 : fill_q;
  assign fill_inc  = (fill_base == (AW+1)'(DEPTH)) ? fill_base : fill_base + (AW+1)'(1);

  // D=DEPTH has low bits zero, so the AW-bit subtraction wraps to DEPTH-1 as needed.
  assign rd_off  = d_eff[AW-1:0] - AW'(1);
  assign rd_idx  = wr_ptr_q - rd_off;
  assign rd_data = mem[rd_idx];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    cur_delay_d = d_eff;
    data_out_d  = data_out_q;
    out_valid_d = out_valid_q;
    if (flush_any) begin
      fill_d      = '0;
      data_out_d  = '0;
      out_valid_d = 1'b0;
    end
    if (shift_enable) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      fill_d   = fill_inc;
      if (fill_inc >= d_eff) begin
        out_valid_d = 1'b1;
        data_out_d  = (d_eff == (AW+1)'(1)) ? data_in : rd_data;
      end else begin
        out_valid_d = 1'b0;
        data_out_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      cur_delay_q <= (AW+1)'(DEPTH);
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      cur_delay_q <= cur_delay_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_enable && !rst) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;
  assign cur_delay = cur_delay_q;

endmodule

// File: tb/tb_prog_delay_line.sv
// Directed bench for prog_delay_line: long fill/wrap loops plus a table of
// hand-computed vectors for bypass, clamping, flush and reset corner cases.
module tb_prog_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             shift_enable;
  logic [WIDTH-1:0] data_in;
  logic             cfg_load;
  logic [AW:0]      delay_cfg;
  logic             flush;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic [AW:0]      cur_delay;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .shift_enable (shift_enable),
    .data_in      (data_in),
    .cfg_load     (cfg_load),
    .delay_cfg    (delay_cfg),
    .flush        (flush),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .cur_delay    (cur_delay)
  );

  typedef struct {
    logic             rst;
    logic             sh;
    logic             ld;
    logic             fl;
    logic [AW:0]      cfg;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] eout;
    logic             evalid;
    logic [AW:0]      edly;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic sh, input logic ld, input logic fl,
                              input int cfg, input int din, input int eout,
                              input logic evalid, input int edly);
    vec_t v;
    v.rst = r; v.sh = sh; v.ld = ld; v.fl = fl;
    v.cfg = cfg[AW:0]; v.din = din[WIDTH-1:0];
    v.eout = eout[WIDTH-1:0]; v.evalid = evalid; v.edly = edly[AW:0];
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] eout,
                       input logic evalid, input logic [AW:0] edly);
    checks++;
    if (data_out !== eout || out_valid !== evalid || cur_delay !== edly) begin
      errors++;
      $display("FAIL %s: got out=%h valid=%b delay=%0d, want out=%h valid=%b delay=%0d",
               name, data_out, out_valid, cur_delay, eout, evalid, edly);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic sh, input logic ld, input logic fl,
                      input logic [AW:0] cfg, input logic [WIDTH-1:0] din);
    @(negedge clk);
    rst = r; shift_enable = sh; cfg_load = ld; flush = fl; delay_cfg = cfg; data_in = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; shift_enable = 1'b0; cfg_load = 1'b0; flush = 1'b0;
    delay_cfg = '0; data_in = '0;

    // Test 1: reset defaults, then fill the full DEPTH line.
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    check("reset", 8'h00, 1'b0, 9'd256);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'(i));
      check("fill_dmax", 8'h00, 1'b0, 9'd256);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'(DEPTH));
    check("first_dmax", 8'h01, 1'b1, 9'd256);

    // Test 4: D=DEPTH, incrementing counter across several pointer wraps.
    step(1'b0, 1'b0, 1'b1, 1'b0, 9'd256, 8'd0);
    check("load_dmax", 8'h00, 1'b0, 9'd256);
    for (int k = 0; k < 3 * DEPTH; k++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'(k));
      if (k >= DEPTH - 1) check("wrap", 8'(k - (DEPTH - 1)), 1'b1, 9'd256);
      else                check("wrap_fill", 8'h00, 1'b0, 9'd256);
    end

    // Test 2: D=1 bypass.
    add(0, 0, 1, 0, 1, 0, 8'h00, 0, 1);
    add(0, 1, 0, 0, 0, 8'hA5, 8'hA5, 1, 1);
    // Test 3: D=4, then 3 idle cycles hold.
    add(0, 0, 1, 0, 4, 0, 8'h00, 0, 4);
    for (int j = 0; j < 16; j++) begin
      if (j < 3) add(0, 1, 0, 0, 0, 8'h10 + j, 8'h00, 0, 4);
      else       add(0, 1, 0, 0, 0, 8'h10 + j, 8'h10 + j - 3, 1, 4);
    end
    for (int j = 0; j < 3; j++) add(0, 0, 0, 0, 0, 8'hEE, 8'h1C, 1, 4);
    // Test 5: clamp low and high mid-stream.
    add(0, 1, 0, 0, 0, 8'h20, 8'h1D, 1, 4);
    add(0, 0, 1, 0, 0, 0, 8'h00, 0, 1);
    add(0, 1, 0, 0, 0, 8'h33, 8'h33, 1, 1);
    add(0, 0, 1, 0, DEPTH + 5, 0, 8'h00, 0, 256);
    add(0, 1, 0, 0, 0, 8'h44, 8'h00, 0, 256);
    // Test 6: flush with shift counts as first sample of the new fill.
    add(0, 0, 1, 0, 4, 0, 8'h00, 0, 4);
    add(0, 1, 0, 0, 0, 8'h01, 8'h00, 0, 4);
    add(0, 1, 0, 0, 0, 8'h02, 8'h00, 0, 4);
    add(0, 1, 0, 0, 0, 8'h03, 8'h00, 0, 4);
    add(0, 1, 0, 1, 0, 8'h50, 8'h00, 0, 4);
    add(0, 1, 0, 0, 0, 8'h51, 8'h00, 0, 4);
    add(0, 1, 0, 0, 0, 8'h52, 8'h00, 0, 4);
    add(0, 1, 0, 0, 0, 8'h53, 8'h50, 1, 4);
    add(0, 0, 1, 0, 1, 0, 8'h00, 0, 1);
    add(0, 1, 0, 0, 0, 8'h60, 8'h60, 1, 1);
    add(0, 0, 1, 0, 3, 0, 8'h00, 0, 3);
    add(0, 1, 0, 0, 0, 8'h61, 8'h00, 0, 3);
    add(0, 0, 0, 1, 0, 0, 8'h00, 0, 3);
    add(0, 1, 1, 0, 1, 8'h77, 8'h77, 1, 1);
    add(0, 1, 1, 0, 4, 8'h78, 8'h00, 0, 4);
    add(0, 1, 0, 0, 0, 8'h79, 8'h00, 0, 4);
    add(1, 1, 0, 0, 0, 8'h7A, 8'h00, 0, 256);
    add(0, 1, 0, 0, 0, 8'h7B, 8'h00, 0, 256);

    for (int n = 0; n < vq.size(); n++) begin
      step(vq[n].rst, vq[n].sh, vq[n].ld, vq[n].fl, vq[n].cfg, vq[n].din);
      check($sformatf("vec%0d", n), vq[n].eout, vq[n].evalid, vq[n].edly);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
